// File: rtl/rt_mod_n_pkg.sv
// Shared types and constants for the real-time mod-N counter chain controller.
package rt_mod_n_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    SET  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEC = 2'd0,
    SEL_MIN = 2'd1,
    SEL_HR  = 2'd2,
    SEL_BAD = 2'd3
  } sel_t;

endpackage

// File: rtl/rt_mod_n_ctrl_cell.sv
// mod_n_cell: one 8-bit modulo-MOD counter stage with load, increment and carry-out.
module mod_n_cell
  import rt_mod_n_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             carry
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  assign carry = inc && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n)   count <= '0;
    else if (load)  count <= load_val;
    else if (inc)   count <= carry ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/rt_mod_n_ctrl.sv
// Sequencing controller: prescaler, STOP/RUN/SET FSM and host time-set arbitration
// over three cascaded mod_n_cell stages. Optional alarm via RT_MOD_N_CTRL_ALARM_EN.
module rt_mod_n_ctrl
  import rt_mod_n_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_en,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [1:0]       set_sel,
  input  logic [CNT_W-1:0] set_value,
  output logic             set_err,
  output logic [CNT_W-1:0] sec_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] hr_o,
  output logic             running_o,
  output logic             day_pulse
`ifdef RT_MOD_N_CTRL_ALARM_EN
  ,
  input  logic             alarm_set,
  input  logic [CNT_W-1:0] alarm_hr,
  input  logic [CNT_W-1:0] alarm_min,
  output logic             alarm_pulse
`endif
);

  localparam int               PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SEC_MOD - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_MOD - 1);
  localparam logic [CNT_W-1:0] HR_LAST  = CNT_W'(HR_MOD - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q;
  sel_t             sel_q;
  logic [CNT_W-1:0] val_q;
  logic             set_err_q, day_pulse_q;
  logic             counting, tick, in_set, legal;
  logic             sec_carry, min_carry, hr_carry;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= STOP;
    else          state_q <= state_d;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    set_ready = 1'b0;
    unique case (state_q)
      STOP: begin
        set_ready = 1'b1;
        if (set_valid)   state_d = SET;
        else if (run_en) state_d = RUN;
      end
      RUN:     if (!run_en) state_d = STOP;
      SET:     state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // NOTE: the write capture holds pure data qualified by the SET state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == STOP && set_valid) begin
      sel_q <= sel_t'(set_sel);
      val_q <= set_value;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (sel_q)
      SEL_SEC: legal = (val_q <= SEC_LAST);
      SEL_MIN: legal = (val_q <= MIN_LAST);
      SEL_HR:  legal = (val_q <= HR_LAST);
      default: legal = 1'b0;
    endcase
  end

  assign in_set   = (state_q == SET);
  // A falling run_en pauses on this very edge, leaving the prescaler where it was.
  assign counting = (state_q == RUN) && run_en;
  assign tick     = counting && (presc_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q     <= '0;
      set_err_q   <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      if (counting) presc_q <= tick ? '0 : presc_q + 1'b1;
      set_err_q   <= in_set && !legal;
      day_pulse_q <= hr_carry;
    end
  end

  mod_n_cell #(.MOD(SEC_MOD)) u_sec (
    .clk, .reset_n, .inc(tick), .load(in_set && legal && sel_q == SEL_SEC),
    .load_val(val_q), .count(sec_o), .carry(sec_carry)
  );

  mod_n_cell #(.MOD(MIN_MOD)) u_min (
    .clk, .reset_n, .inc(sec_carry), .load(in_set && legal && sel_q == SEL_MIN),
    .load_val(val_q), .count(min_o), .carry(min_carry)
  );

  mod_n_cell #(.MOD(HR_MOD)) u_hr (
    .clk, .reset_n, .inc(min_carry), .load(in_set && legal && sel_q == SEL_HR),
    .load_val(val_q), .count(hr_o), .carry(hr_carry)
  );

  assign set_err   = set_err_q;
  assign day_pulse = day_pulse_q;
  assign running_o = (state_q == RUN);

`ifdef RT_MOD_N_CTRL_ALARM_EN
  logic [CNT_W-1:0] alarm_hr_q, alarm_min_q, min_next, hr_next;
  logic             alarm_pulse_q;

  // Values the minute/hour cells take on the edge where seconds wrap.
  assign min_next = min_carry ? '0 : min_o + 1'b1;
  assign hr_next  = hr_carry ? '0 : (min_carry ? hr_o + 1'b1 : hr_o);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alarm_hr_q    <= '0;
      alarm_min_q   <= '0;
      alarm_pulse_q <= 1'b0;
    end else begin
      if (state_q == STOP && alarm_set && alarm_hr <= HR_LAST && alarm_min <= MIN_LAST) begin
        alarm_hr_q  <= alarm_hr;
        alarm_min_q <= alarm_min;
      end
      alarm_pulse_q <= sec_carry && (min_next == alarm_min_q) && (hr_next == alarm_hr_q);
    end
  end

  assign alarm_pulse = alarm_pulse_q;
`endif

endmodule

// File: tb/tb_rt_mod_n_ctrl.sv
// Self-checking bench for rt_mod_n_ctrl (CLK_DIV=4, 60/60/24); alarm test only with RT_MOD_N_CTRL_ALARM_EN.
module tb_rt_mod_n_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_en = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [1:0] set_sel = 2'd0;
  logic [7:0] set_value = 8'd0;
  logic       set_err;
  logic [7:0] sec_o, min_o, hr_o;
  logic       running_o, day_pulse;
`ifdef RT_MOD_N_CTRL_ALARM_EN
  logic       alarm_set = 1'b0;
  logic [7:0] alarm_hr = 8'd0, alarm_min = 8'd0;
  logic       alarm_pulse;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rt_mod_n_ctrl #(.CLK_DIV(4), .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .set_valid(set_valid),
    .set_ready(set_ready), .set_sel(set_sel), .set_value(set_value), .set_err(set_err),
    .sec_o(sec_o), .min_o(min_o), .hr_o(hr_o), .running_o(running_o), .day_pulse(day_pulse)
`ifdef RT_MOD_N_CTRL_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_pulse(alarm_pulse)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run_en = 1'b0; set_valid = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  // Full host handshake; err returns set_err as seen in the cycle after SET.
  task automatic do_write(input logic [1:0] sel, input logic [7:0] val, output logic err);
    set_sel = sel; set_value = val; set_valid = 1'b1;
    for (int i = 0; i < 8 && !set_ready; i++) cyc();
    n_checks++;
    if (set_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_ready: set_ready=%b expected 1", set_ready);
    end
    cyc();
    set_valid = 1'b0;
    n_checks++;
    if (set_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_set_state_ready: set_ready=%b expected 0", set_ready);
    end
    cyc();
    err = set_err;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({sec_o, min_o, hr_o} !== 24'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", hr_o, min_o, sec_o);
    end
    n_checks++;
    if ({running_o, set_err, day_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: running/err/day=%b expected 000", {running_o, set_err, day_pulse});
    end
    n_checks++;
    if (set_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: set_ready=%b expected 1 (STOP)", set_ready);
    end
  endtask

  task automatic test_count();
    logic [7:0] prev;
    exp_t e;
    do_reset();
    push_exp(4, 8'd1); push_exp(8, 8'd2); push_exp(12, 8'd3);
    run_en = 1'b1;
    cyc();
    n_checks++;
    if (running_o !== 1'b1) begin
      n_fail++; $display("FAIL count_running: running_o=%b expected 1", running_o);
    end
    prev = sec_o;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (sec_o !== prev) begin
        prev = sec_o;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL count_extra: sec_o changed to %0d at cycle %0d, expected no change", sec_o, k);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || sec_o !== e.val) begin
            n_fail++; $display("FAIL count_tick: sec_o=%0d at cycle %0d, expected %0d at cycle %0d", sec_o, k, e.val, e.cyc);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL count_missing: %0d ticks not seen, expected 0", sb.size());
    end
    sb.delete();
    run_en = 1'b0;
    cyc();
    n_checks++;
    if (running_o !== 1'b0 || sec_o !== 8'd3) begin
      n_fail++; $display("FAIL count_stop: running=%b sec=%0d expected 0 and 3", running_o, sec_o);
    end
  endtask

  task automatic test_day_wrap();
    logic err;
    int   pulses;
    exp_t e;
    do_reset();
    do_write(2'd0, 8'd59, err);
    do_write(2'd1, 8'd59, err);
    do_write(2'd2, 8'd23, err);
    n_checks++;
    if ({hr_o, min_o, sec_o} !== {8'd23, 8'd59, 8'd59} || day_pulse !== 1'b0) begin
      n_fail++; $display("FAIL day_preset: got %0d:%0d:%0d day=%b expected 23:59:59 day=0", hr_o, min_o, sec_o, day_pulse);
    end
    push_exp(5, 8'd0);
    pulses = 0;
    run_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (day_pulse === 1'b1) begin
        pulses++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL day_extra: day_pulse at cycle %0d, expected none", k);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || {hr_o, min_o, sec_o} !== {3{e.val}}) begin
            n_fail++; $display("FAIL day_wrap: pulse at cycle %0d time %0d:%0d:%0d, expected cycle %0d time 0:0:0", k, hr_o, min_o, sec_o, e.cyc);
          end
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL day_pulse_count: %0d pulses, expected 1", pulses);
    end
    sb.delete();
    run_en = 1'b0;
    cyc();
  endtask

  task automatic test_illegal();
    logic err;
    do_reset();
    do_write(2'd1, 8'd7, err);
    n_checks++;
    if (err !== 1'b0 || min_o !== 8'd7) begin
      n_fail++; $display("FAIL legal_min: err=%b min=%0d expected 0 and 7", err, min_o);
    end
    do_write(2'd1, 8'd60, err);
    n_checks++;
    if (err !== 1'b1 || min_o !== 8'd7) begin
      n_fail++; $display("FAIL illegal_min: err=%b min=%0d expected 1 and 7", err, min_o);
    end
    cyc();
    n_checks++;
    if (set_err !== 1'b0) begin
      n_fail++; $display("FAIL err_width: set_err=%b one cycle later, expected 0", set_err);
    end
    do_write(2'd3, 8'd1, err);
    n_checks++;
    if (err !== 1'b1 || {hr_o, min_o, sec_o} !== {8'd0, 8'd7, 8'd0}) begin
      n_fail++; $display("FAIL illegal_sel: err=%b time %0d:%0d:%0d expected 1, 0:7:0", err, hr_o, min_o, sec_o);
    end
    do_write(2'd2, 8'd24, err);
    n_checks++;
    if (err !== 1'b1 || hr_o !== 8'd0) begin
      n_fail++; $display("FAIL illegal_hr: err=%b hr=%0d expected 1 and 0", err, hr_o);
    end
    do_write(2'd2, 8'd23, err);
    n_checks++;
    if (err !== 1'b0 || hr_o !== 8'd23) begin
      n_fail++; $display("FAIL edge_hr: err=%b hr=%0d expected 0 and 23", err, hr_o);
    end
  endtask

  task automatic test_set_during_run();
    logic [7:0] prev;
    exp_t e;
    do_reset();
    run_en = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) cyc();
    set_sel = 2'd1; set_value = 8'd42; set_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (set_ready !== 1'b0) begin
        n_fail++; $display("FAIL run_ready: set_ready=%b in RUN, expected 0", set_ready);
      end
      cyc();
    end
    run_en = 1'b0;
    n_checks++;
    if (sec_o !== 8'd2 || set_ready !== 1'b0) begin
      n_fail++; $display("FAIL run_hold: sec=%0d ready=%b expected 2 and 0", sec_o, set_ready);
    end
    for (int i = 0; i < 8 && !set_ready; i++) cyc();
    n_checks++;
    if (set_ready !== 1'b1) begin
      n_fail++; $display("FAIL stop_ready: set_ready=%b after pause, expected 1", set_ready);
    end
    cyc();
    set_valid = 1'b0;
    cyc();
    n_checks++;
    if (min_o !== 8'd42 || sec_o !== 8'd2 || set_err !== 1'b0) begin
      n_fail++; $display("FAIL run_write: min=%0d sec=%0d err=%b expected 42, 2, 0", min_o, sec_o, set_err);
    end
    push_exp(3, 8'd3);
    run_en = 1'b1;
    cyc();
    prev = sec_o;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (sec_o !== prev) begin
        prev = sec_o;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL resume_extra: sec_o=%0d at cycle %0d, expected no change", sec_o, k);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || sec_o !== e.val) begin
            n_fail++; $display("FAIL resume_tick: sec_o=%0d at cycle %0d, expected %0d at cycle %0d", sec_o, k, e.val, e.cyc);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL resume_missing: %0d ticks not seen, expected 0", sb.size());
    end
    sb.delete();
    run_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_abort();
    logic err;
    do_reset();
    do_write(2'd1, 8'd5, err);
    set_sel = 2'd0; set_value = 8'd30; set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
    reset_n = 1'b0;
    cyc();
    n_checks++;
    if ({hr_o, min_o, sec_o} !== 24'd0 || {running_o, set_err, day_pulse, set_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL abort_set: time %0d:%0d:%0d run/err/day/ready=%b expected 0:0:0 0001", hr_o, min_o, sec_o, {running_o, set_err, day_pulse, set_ready});
    end
    reset_n = 1'b1;
    cyc();
    n_checks++;
    if (sec_o !== 8'd0) begin
      n_fail++; $display("FAIL abort_write_dropped: sec=%0d expected 0", sec_o);
    end
    run_en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    reset_n = 1'b0;
    cyc();
    n_checks++;
    if ({hr_o, min_o, sec_o} !== 24'd0 || running_o !== 1'b0 || set_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_count: time %0d:%0d:%0d running=%b ready=%b expected 0:0:0 0 1", hr_o, min_o, sec_o, running_o, set_ready);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 4) begin
        n_checks++;
        if (sec_o !== 8'd0) begin
          n_fail++; $display("FAIL abort_presc_clear: sec=%0d at cycle 4, expected 0", sec_o);
        end
      end
    end
    n_checks++;
    if (sec_o !== 8'd1) begin
      n_fail++; $display("FAIL abort_first_tick: sec=%0d at cycle 5, expected 1", sec_o);
    end
    run_en = 1'b0;
    cyc();
  endtask

`ifdef RT_MOD_N_CTRL_ALARM_EN
  task automatic test_alarm();
    logic err;
    int   pulses;
    exp_t e;
    do_reset();
    do_write(2'd0, 8'd56, err);
    alarm_hr = 8'd0; alarm_min = 8'd1; alarm_set = 1'b1;
    cyc();
    alarm_min = 8'd60; alarm_hr = 8'd5;
    cyc();
    alarm_set = 1'b0;
    push_exp(17, 8'd1);
    pulses = 0;
    run_en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      if (alarm_pulse === 1'b1) begin
        pulses++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL alarm_extra: alarm_pulse at cycle %0d, expected none", k);
        end else begin
          e = sb.pop_front();
          if (k != e.cyc || min_o !== e.val || sec_o !== 8'd0 || hr_o !== 8'd0) begin
            n_fail++; $display("FAIL alarm_hit: pulse at cycle %0d time %0d:%0d:%0d, expected cycle %0d time 0:1:0", k, hr_o, min_o, sec_o, e.cyc);
          end
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL alarm_count: %0d pulses, expected 1", pulses);
    end
    sb.delete();
    run_en = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_illegal();
    test_set_during_run();
    test_reset_abort();
`ifdef RT_MOD_N_CTRL_ALARM_EN
    test_alarm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_mod_n_ctrl.md
Name: rt_mod_n_ctrl

Overview:
Sequencing controller for the real-time mod-N counter chain.
- Prescales clk into a seconds tick and drives three cascaded mod-N counter cells (sec/min/hr) with enable and carry.
- Arbitrates between free-running count and host time-set writes via a valid/ready handshake.
- Sits between the host register interface and the counter datapath.

Parameters:
CLK_DIV, 4, clk cycles per seconds tick (>=2)
SEC_MOD, 60, seconds modulus (2..256)
MIN_MOD, 60, minutes modulus (2..256)
HR_MOD, 24, hours modulus (2..256)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
run_en  input  1  level; 1 = count, 0 = pause
set_valid  input  1  host write request
set_ready  output  1  controller accepts write this cycle
set_sel  input  2  target: 0=sec, 1=min, 2=hr, 3=illegal
set_value  input  8  value to load
set_err  output  1  one-cycle pulse: rejected write
sec_o  output  8  seconds count
min_o  output  8  minutes count
hr_o  output  8  hours count
running_o  output  1  state == RUN
day_pulse  output  1  one-cycle pulse on full hr/min/sec wrap

Behaviour:
- Interface: one clock, clk. Reset, reset_n, is synchronous and active-low.
- Reset (reset_n=0 at an edge): state=STOP, prescaler=0, sec_o/min_o/hr_o=0, set_err=0, day_pulse=0, running_o=0. Reset mid-count or mid-SET aborts everything; any pending write is discarded.
- FSM states: STOP, RUN, SET.
- STOP:
  - set_ready=1.
  - set_valid=1 -> capture set_sel/set_value, go to SET. Set has priority over run_en.
  - Else run_en=1 -> RUN.
- SET:
  - set_ready=0.
  - Write captured value to the selected counter this cycle, then return to STOP.
  - Illegal write: set_sel==3 or set_value >= that field's MOD. Counters unchanged; set_err=1 in the cycle following SET (registered).
- RUN:
  - set_ready=0; host must hold set_valid until ready.
  - run_en=0 -> STOP. Prescaler holds its value (pause, not clear).
- Prescaler: counts 0..CLK_DIV-1 only in RUN. On the edge where it equals CLK_DIV-1:
  - Prescaler wraps to 0.
  - sec increments.
  - First sec increment occurs CLK_DIV cycles after entering RUN from prescaler=0.
- Carry: on the same tick edge:
  - sec==SEC_MOD-1 -> sec wraps to 0 and min increments.
  - Additionally min==MIN_MOD-1 -> min wraps and hr increments.
  - hr==HR_MOD-1 wraps to 0.
  - All three wrap on the same edge.
- day_pulse: registered; high exactly the cycle in which sec_o/min_o/hr_o first read 0/0/0 after a full wrap. Never high from reset or from a SET write.
- Counter outputs are registered; no combinational path from inputs to outputs except set_ready (decoded from state).
- Arithmetic: counters are 8-bit unsigned; MOD-1 comparisons use 8-bit constants; no overflow past MOD-1 is reachable.

Optional Feature:
Macro: RT_MOD_N_CTRL_ALARM_EN.
- Defined:
  - Adds ports alarm_set (input 1), alarm_hr/alarm_min (input 8 each), alarm_pulse (output 1).
  - alarm_set=1 in STOP latches the compare values; illegal values are ignored.
  - alarm_pulse is a one-cycle registered pulse when hr_o/min_o become equal to the alarm values with sec_o==0 by counting. Writes never trigger it.
  - Reset clears the alarm registers to 0 and alarm_pulse to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package rt_mod_n_pkg:
  - State enum {STOP, RUN, SET}.
  - Field select enum {SEL_SEC, SEL_MIN, SEL_HR, SEL_BAD}.
  - CNT_W=8 constant.
- Sub-module mod_n_cell (parameter MOD), instantiated three times. Inputs: clk, reset_n, inc, load, load_val. Outputs: count, carry (comb: inc && count==MOD-1).
- Controller owns the FSM, prescaler, error and day_pulse registers.

Test Plan:
- Reset, run_en=1 for 12 cycles, CLK_DIV=4 -> sec_o increments at cycles 4, 8, 12 (values 1, 2, 3); running_o=1.
- Set sec=59, min=59, hr=23 via three handshakes in STOP, then run 4 cycles -> all 0, day_pulse high exactly one cycle.
- set_valid with set_sel=1, set_value=60 -> set_ready handshake completes, set_err one-cycle pulse, min_o unchanged.
- set_valid asserted during RUN -> set_ready=0 until run_en=0; write then lands in STOP with value correct, count paused with prescaler held.
- Assert reset_n=0 in SET and mid-count -> next cycle all outputs 0, state STOP, write not applied.
- ALARM_EN build: alarm 0:1, start 0:0:56 -> alarm_pulse one cycle when min_o becomes 1.
